iir_mac_scheduler: RTL and testbench

Time-multiplexed controller that runs NCH independent second-order IIR (biquad) sections through one shared signed 16x16 multiply-accumulate unit. Each sample strobe starts a fixed sequence: 5 MAC steps per channel, then a writeback. The block holds per-channel coefficient registers and filter history, and it flags overrun when samples arrive faster than the sequence can finish. It sits between the audio front end (sample strobe per frame) and the feature stages that consume filtered envelopes.

---
 rtl/iir_mac_scheduler.sv | 152 +++++++++++++++
 tb/tb_iir_mac_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_mac_scheduler.sv
// Time-multiplexed biquad controller: NCH channels share one signed 16x16 MAC, 5 taps + writeback each.
// Optional IIR_SCHED_SAT_EN: writeback clamps to 16 bits instead of wrapping.
module iir_mac_scheduler #(
    parameter int NCH       = 2,
    parameter int COEF_FRAC = 14
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_sample_valid,
    input  logic [16*NCH-1:0]           i_sample_in,
    input  logic [2:0]                  i_scale,
    input  logic                        i_cfg_we,
    input  logic [$clog2(5*NCH)-1:0]    i_cfg_addr,
    input  logic signed [15:0]          i_cfg_data,
    output logic                        o_busy,
    output logic                        o_out_valid,
    output logic [16*NCH-1:0]           o_audio_out,
    output logic                        o_overrun
);
    localparam int NREG = 5 * NCH;
    localparam int AW   = $clog2(NREG);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

    state_t             r_state;
    logic [CHW-1:0]     r_ch;
    logic [2:0]         r_tap;
    logic signed [19:0] r_acc;
    logic               r_out_valid;
    logic               r_overrun;
    logic signed [15:0] r_coef [NREG];
    logic signed [15:0] r_x0 [NCH];
    logic signed [15:0] r_x1 [NCH];
    logic signed [15:0] r_x2 [NCH];
    logic signed [15:0] r_y1 [NCH];
    logic signed [15:0] r_y2 [NCH];

    logic [AW-1:0]      w_cidx;
    logic signed [15:0] w_coef;
    logic signed [15:0] w_v;
    logic signed [31:0] w_prod;
    logic signed [19:0] w_term;
    logic signed [15:0] w_y;

    function automatic logic signed [15:0] f_wb(input logic signed [19:0] acc,
                                                input logic [2:0] sh);
        logic signed [22:0] t;
        t = 23'(acc) <<< sh;
`ifdef IIR_SCHED_SAT_EN
        if (t > 23'sd32767)
            return 16'sh7FFF;
        else if (t < -23'sd32768)
            return 16'sh8000;
        else
            return t[15:0];
`else
        return t[15:0];
`endif
    endfunction

    assign w_cidx = AW'(r_ch) * AW'(5) + AW'(r_tap);
    assign w_coef = r_coef[w_cidx];

    always_comb begin
        w_v = '0;
        case (r_tap)
            3'd0:    w_v = r_x0[r_ch];
            3'd1:    w_v = r_x1[r_ch];
            3'd2:    w_v = r_x2[r_ch];
            3'd3:    w_v = r_y1[r_ch];
            3'd4:    w_v = r_y2[r_ch];
            default: w_v = '0;
        endcase
    end

    assign w_prod = 32'(w_coef) * 32'(w_v);
    assign w_term = 20'(w_prod >>> COEF_FRAC);
    assign w_y    = f_wb(r_acc, i_scale);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_tap       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < NREG; i++)
                r_coef[i] <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_x0[c] <= '0;
                r_x1[c] <= '0;
                r_x2[c] <= '0;
                r_y1[c] <= '0;
                r_y2[c] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (i_sample_valid && r_state != S_IDLE)
                r_overrun <= 1'b1;
            // Writes land while idle, including the edge that accepts a sample.
            if (i_cfg_we && r_state == S_IDLE && i_cfg_addr < AW'(NREG))
                r_coef[i_cfg_addr] <= i_cfg_data;
            case (r_state)
                S_IDLE: begin
                    if (i_sample_valid) begin
                        for (int c = 0; c < NCH; c++)
                            r_x0[c] <= $signed(i_sample_in[16*c +: 16]);
                        r_ch    <= '0;
                        r_tap   <= '0;
                        r_acc   <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_term;
                    if (r_tap == 3'd4)
                        r_state <= S_WB;
                    else
                        r_tap <= r_tap + 3'd1;
                end
                S_WB: begin
                    r_x2[r_ch] <= r_x1[r_ch];
                    r_x1[r_ch] <= r_x0[r_ch];
                    r_y2[r_ch] <= r_y1[r_ch];
                    r_y1[r_ch] <= w_y;
                    if (r_ch == CHW'(NCH - 1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_ch    <= r_ch + CHW'(1);
                        r_tap   <= '0;
                        r_acc   <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The newest output of each channel is exactly its y1 history entry.
    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign o_audio_out[16*g +: 16] = r_y1[g];
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Scoreboard bench for iir_mac_scheduler: directed cases plus randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_iir_mac_scheduler;
    localparam int NCH  = 2;
    localparam int NREG = 5 * NCH;
    localparam int AW   = $clog2(NREG);
    localparam int SEQ  = 6 * NCH + 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                sample_valid = 1'b0;
    logic [16*NCH-1:0]   sample_in = '0;
    logic [2:0]          scale = '0;
    logic                cfg_we = 1'b0;
    logic [AW-1:0]       cfg_addr = '0;
    logic signed [15:0]  cfg_data = '0;
    logic                busy;
    logic                out_valid;
    logic [16*NCH-1:0]   audio_out;
    logic                overrun;

    iir_mac_scheduler #(.NCH(NCH), .COEF_FRAC(14)) dut (
        .clk(clk), .reset(reset),
        .i_sample_valid(sample_valid), .i_sample_in(sample_in), .i_scale(scale),
        .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
        .o_busy(busy), .o_out_valid(out_valid), .o_audio_out(audio_out), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int vals[NCH];
        int cyc;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad = 0;

    // reference model state
    int mcoef[NREG];
    int mx1[NCH], mx2[NCH], my1[NCH], my2[NCH];
    int last_a = -1000;
    bit m_ovr = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at edge %0d", name, got, exp, edge_cnt);
        end
    endtask

    function automatic int wrapn(input longint v, input int bits);
        longint m, r;
        m = longint'(1) << bits;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return int'(r);
    endfunction

    function automatic int floor_q14(input longint p);
        longint qv;
        qv = p / 16384;
        if (p < 0 && qv * 16384 != p) qv -= 1;
        return int'(qv);
    endfunction

    function automatic int ref_wb(input int acc, input int sh);
        longint t;
        t = wrapn(longint'(acc) * (longint'(1) << sh), 23);
`ifdef IIR_SCHED_SAT_EN
        if (t > 32767) return 32767;
        if (t < -32768) return -32768;
        return int'(t);
`else
        return wrapn(t, 16);
`endif
    endfunction

    function automatic int s16(input int v);
        return wrapn(longint'(v), 16);
    endfunction

    function automatic int ch_out(input int c);
        logic signed [15:0] v;
        v = audio_out[16*c +: 16];
        return int'(v);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) mcoef[i] = 0;
        for (int c = 0; c < NCH; c++) begin
            mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
        end
        last_a = -1000;
        m_ovr = 1'b0;
    endtask

    task automatic step();
        bit exp_busy;
        @(posedge clk);
        #1;
        exp_busy = (edge_cnt >= last_a) && (edge_cnt <= last_a + SEQ - 1);
        check("busy", int'(busy), int'(exp_busy));
        check("overrun", int'(overrun), int'(m_ovr));
    endtask

    task automatic drive(input bit v, input logic [16*NCH-1:0] s, input bit we,
                         input int addr, input int data);
        int e, acc, y, a;
        int vv[5];
        bit idle;
        exp_t x;
        e = edge_cnt;
        sample_valid = v;
        sample_in = s;
        cfg_we = we;
        cfg_addr = AW'(addr);
        cfg_data = 16'(data);
        idle = (e >= last_a + SEQ);
        if (we && idle && addr < NREG) mcoef[addr] = s16(data);
        if (v) begin
            if (idle) begin
                a = e + 1;
                last_a = a;
                for (int c = 0; c < NCH; c++) begin
                    vv[0] = s16(int'(s[16*c +: 16]));
                    vv[1] = mx1[c]; vv[2] = mx2[c]; vv[3] = my1[c]; vv[4] = my2[c];
                    acc = 0;
                    for (int k = 0; k < 5; k++)
                        acc += floor_q14(longint'(mcoef[5*c + k]) * longint'(vv[k]));
                    y = ref_wb(wrapn(longint'(acc), 20), int'(scale));
                    x.vals[c] = y;
                    mx2[c] = mx1[c]; mx1[c] = vv[0];
                    my2[c] = my1[c]; my1[c] = y;
                end
                x.cyc = a + SEQ - 1;
                q.push_back(x);
            end else begin
                m_ovr = 1'b1;
            end
        end
        step();
        sample_valid = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        int e;
        e = edge_cnt;
        while (q.size() > 0 && q[$].cyc > e) void'(q.pop_back());
        model_clear();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        while (edge_cnt < last_a + SEQ) step();
    endtask

    task automatic wr(input int addr, input int data);
        wait_idle();
        drive(1'b0, sample_in, 1'b1, addr, data);
    endtask

    task automatic samp(input int s0, input int s1);
        drive(1'b1, {16'(s1), 16'(s0)}, 1'b0, 0, 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid got=1 exp=0 at edge %0d", edge_cnt);
            end else begin
                exp_t x;
                x = q.pop_front();
                check("out_cycle", edge_cnt, x.cyc);
                for (int c = 0; c < NCH; c++) check($sformatf("audio_ch%0d", c), ch_out(c), x.vals[c]);
            end
        end else if (q.size() > 0 && q[0].cyc < edge_cnt) begin
            exp_t x;
            x = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_out_valid got=0 exp=1 at edge %0d (due %0d)", edge_cnt, x.cyc);
        end
    end

    initial begin
        int fb_exp[4];
        model_clear();
        do_reset();
        do_reset();
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_audio", int'(audio_out), 0);
        check("rst_overrun", int'(overrun), 0);

        // passthrough
        wr(0, 16'h4000);
        wr(5, 16'h2000);
        samp(1000, -1000);
        repeat (SEQ - 1) step();
        check("pt_out_valid_c13", int'(out_valid), 1);
        check("pt_busy_c13", int'(busy), 1);
        step();
        check("pt_busy_c14", int'(busy), 0);
        check("pt_ch0", ch_out(0), 1000);
        check("pt_ch1", ch_out(1), -500);

        // delay tap
        do_reset();
        wr(1, 16'h4000);
        samp(500, 0); wait_idle(); check("dly_0", ch_out(0), 0);
        samp(700, 0); wait_idle(); check("dly_1", ch_out(0), 500);
        samp(0, 0);   wait_idle(); check("dly_2", ch_out(0), 700);

        // feedback
        do_reset();
        wr(0, 16'h4000);
        wr(3, 16'h2000);
        fb_exp[0] = 1024; fb_exp[1] = 512; fb_exp[2] = 256; fb_exp[3] = 128;
        for (int i = 0; i < 4; i++) begin
            samp((i == 0) ? 1024 : 0, 0);
            wait_idle();
            check($sformatf("fb_%0d", i), ch_out(0), fb_exp[i]);
        end

        // saturation / wrap
        do_reset();
        wr(0, 16'h7FFF);
        samp(30000, 0);
        wait_idle();
`ifdef IIR_SCHED_SAT_EN
        check("sat", ch_out(0), 32767);
`else
        check("wrap", ch_out(0), -5538);
`endif

        // overrun and config lockout
        do_reset();
        wr(0, 16'h4000);
        wr(5, 16'h2000);
        samp(1000, -1000);
        step();
        step();
        samp(111, 222);
        drive(1'b0, sample_in, 1'b1, 0, 16'h1000);
        check("ovr_set_c5", int'(overrun), 1);
        wait_idle();
        check("ovr_first_ch0", ch_out(0), 1000);
        check("ovr_first_ch1", ch_out(1), -500);
        samp(1234, 0);
        wait_idle();
        check("lockout_readback", ch_out(0), 1234);

        // reset mid-sequence
        samp(1000, -1000);
        repeat (3) step();
        do_reset();
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_audio", int'(audio_out), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        repeat (16) step();
        wr(0, 16'h4000);
        wr(5, 16'h2000);
        samp(1000, -1000);
        wait_idle();
        check("post_rst_ch0", ch_out(0), 1000);
        check("post_rst_ch1", ch_out(1), -500);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit v, we;
            int addr, data;
            if (edge_cnt >= last_a + SEQ && $urandom_range(3) == 0)
                scale = 3'($urandom_range(7));
            v = ($urandom_range(4) == 0);
            we = ($urandom_range(3) == 0);
            addr = int'($urandom_range(2**AW - 1));
            data = int'($urandom_range(16'hFFFF));
            drive(v, {16'($urandom), 16'($urandom)}, we, addr, data);
        end
        wait_idle();
        repeat (4) step();
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
